// File: rtl/rv_arb_pkg.sv
// rtl/rv_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package rv_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/rv_arb_starve_ctr.sv
// rtl/rv_arb_starve_ctr.sv - saturating IF wait counter and starvation-override compare
module rv_arb_starve_ctr
  import rv_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic if_owner,
  output logic starve_hit
);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || if_gnt || !if_req) begin
      wait_cnt <= '0;
    end else if (!if_owner && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starve_hit = (wait_cnt >= WAIT_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/rv_mem_port_arbiter.sv
// rtl/rv_mem_port_arbiter.sv - IF/DM arbiter for the shared single-port word memory
// Define ARB_PERF_EN to add stall and starvation-override counters.
module rv_mem_port_arbiter
  import rv_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall,
  output logic [15:0]       perf_starve
`endif
);

  localparam int LAT_W = 2;

  arb_state_t       state;
  logic             owner;
  logic             acc_we;
  logic             flush_pend;
  logic [LAT_W-1:0] lat_cnt;
  logic             if_want;
  logic             dm_want;
  logic             pick_if;
  logic             if_owner;
  logic             starve_hit;

  // A requester still holds req during its own rvalid cycle; that is not a new request.
  assign if_want  = if_req & ~if_rvalid;
  assign dm_want  = dm_req & ~dm_rvalid;
  assign pick_if  = if_want & (~dm_want | starve_hit);
  assign if_owner = (state != S_IDLE) && (owner == OWN_IF);
  assign stall_if = if_want;
  assign stall_dm = dm_want;

  rv_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_gnt    (if_gnt),
    .if_owner  (if_owner),
    .starve_hit(starve_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      acc_we     <= 1'b0;
      flush_pend <= 1'b0;
      lat_cnt    <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (if_want || dm_want) begin
            owner      <= pick_if ? OWN_IF : OWN_DM;
            acc_we     <= ~pick_if & dm_we;
            flush_pend <= 1'b0;
            if_gnt     <= pick_if;
            dm_gnt     <= ~pick_if;
            mem_en     <= 1'b1;
            mem_we     <= ~pick_if & dm_we;
            mem_addr   <= pick_if ? if_addr : dm_addr;
            mem_wdata  <= pick_if ? '0 : dm_wdata;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= LAT_W'(MEM_LAT - 1);
          state   <= (MEM_LAT == 1) ? S_RESP : S_WAIT;
          if (owner == OWN_IF && if_flush) flush_pend <= 1'b1;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) state <= S_RESP;
          if (owner == OWN_IF && if_flush) flush_pend <= 1'b1;
        end
        S_RESP: begin
          // A flushed fetch still occupies the port but leaves if_rdata untouched.
          if (owner == OWN_DM) begin
            dm_rvalid <= 1'b1;
            dm_rdata  <= acc_we ? '0 : mem_rdata;
          end else if (!(flush_pend || if_flush)) begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_stall <= '0;
      perf_dm_stall <= '0;
      perf_starve   <= '0;
    end else begin
      if (stall_if) perf_if_stall <= perf_if_stall + 32'd1;
      if (stall_dm) perf_dm_stall <= perf_dm_stall + 32'd1;
      if (state == S_IDLE && pick_if && dm_want) perf_starve <= perf_starve + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_mem_port_arbiter.sv
// tb/tb_rv_mem_port_arbiter.sv - self-checking bench for rv_mem_port_arbiter (MEM_LAT 1 and 3 instances)
module tb_rv_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        stall_if, stall_dm, mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        if_req_b, if_flush_b, if_gnt_b, if_rvalid_b;
  logic [9:0]  if_addr_b;
  logic [31:0] if_rdata_b;
  logic        dm_req_b, dm_we_b, dm_gnt_b, dm_rvalid_b;
  logic [9:0]  dm_addr_b;
  logic [31:0] dm_wdata_b, dm_rdata_b;
  logic        stall_if_b, stall_dm_b, mem_en_b, mem_we_b;
  logic [9:0]  mem_addr_b;
  logic [31:0] mem_wdata_b, mem_rdata_b;

`ifdef ARB_PERF_EN
  logic [31:0] perf_if_stall, perf_dm_stall, perf_if_stall_b, perf_dm_stall_b;
  logic [15:0] perf_starve, perf_starve_b;
`endif

  logic [31:0] mem_a   [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] pipe_b  [0:2];
  logic [31:0] mem_q;
  bit          mem_ready = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'h00A00093;
    if (i == 20) return 32'h0000_0055;
    return (32'(i) * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction

  rv_mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall), .perf_starve(perf_starve)
`endif
  );

  rv_mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_flush(if_flush_b),
    .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_gnt(dm_gnt_b), .dm_rvalid(dm_rvalid_b), .dm_rdata(dm_rdata_b),
    .stall_if(stall_if_b), .stall_dm(stall_dm_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
`ifdef ARB_PERF_EN
    , .perf_if_stall(perf_if_stall_b), .perf_dm_stall(perf_dm_stall_b), .perf_starve(perf_starve_b)
`endif
  );

  // 1-cycle-latency read/write memory behind u_dut
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      mem_q <= mem_a[mem_addr];
      if (mem_we) mem_a[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_q;

  // 3-cycle-latency read-only memory behind u_dut_b; data only valid exactly 3 cycles after mem_en
  always @(posedge clk) begin
    pipe_b[0] <= mem_en_b ? init_val(int'(mem_addr_b)) : 32'hBAD0_0000;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_rdata_b = pipe_b[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dm_access(input logic we, input logic [9:0] a, input logic [31:0] wd, input string tag);
    int          we_cyc = 0;
    bit          got = 1'b0;
    logic [31:0] rd = '0;
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (mem_we) begin
        we_cyc++;
        chk({tag, "_we_addr"}, mem_addr, a);
      end
      if (dm_rvalid) begin
        got = 1'b1;
        rd  = dm_rdata;
      end
    end
    dm_req = 1'b0;
    chk({tag, "_done"}, got, 1);
    chk({tag, "_mem_we_cycles"}, we_cyc, we ? 1 : 0);
    if (got) begin
      if (we) begin
        chk({tag, "_store_ack_rdata"}, rd, 0);
        ref_mem[a] = wd;
      end else begin
        chk({tag, "_load_rdata"}, rd, ref_mem[a]);
      end
    end
  endtask

  task automatic if_access(input logic [9:0] a, input string tag);
    bit          got = 1'b0;
    logic [31:0] rd = '0;
    if_addr = a; if_req = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (if_rvalid) begin
        got = 1'b1;
        rd  = if_rdata;
      end
    end
    if_req = 1'b0;
    chk({tag, "_done"}, got, 1);
    if (got) chk({tag, "_rdata"}, rd, ref_mem[a]);
  endtask

  initial begin
    int          gap, max_gap, n_if, early, rv;
    bit          got, gnt2;
    logic [31:0] rd;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if_req_b = 0; if_addr_b = '0; if_flush_b = 0; dm_req_b = 0; dm_we_b = 0; dm_addr_b = '0; dm_wdata_b = '0;
    repeat (3) tick();

    chk("rst_ctrl", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_if, stall_dm}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 0);

    // Test 1: single fetch, MEM_LAT=1
    rst = 1'b0; if_req = 1'b1; if_addr = 10'd5;
    tick();
    chk("t1_if_gnt_c1", if_gnt, 1);
    chk("t1_mem_en_c1", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'd5});
    chk("t1_stall_if_c1", stall_if, 1);
    tick();
    chk("t1_no_gnt_rvalid_c2", {if_gnt, if_rvalid, mem_en}, 0);
    tick();
    chk("t1_if_rvalid_c3", if_rvalid, 1);
    chk("t1_if_rdata_c3", if_rdata, 32'h00A00093);
    chk("t1_stall_if_c3", stall_if, 0);
    if_req = 1'b0;
    tick();
    chk("t1_rvalid_pulse", if_rvalid, 0);

    // Test 2: simultaneous requests, DM first, IF right after
    if_req = 1'b1; if_addr = 10'd11;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
    tick();
    chk("t2_dm_first", {dm_gnt, if_gnt}, 2'b10);
    chk("t2_stall_both", {stall_if, stall_dm}, 2'b11);
    tick();
    tick();
    chk("t2_dm_rvalid", dm_rvalid, 1);
    chk("t2_dm_rdata", dm_rdata, 32'h55);
    chk("t2_if_not_yet", if_gnt, 0);
    dm_req = 1'b0;
    tick();
    chk("t2_if_gnt_after_dm", {if_gnt, dm_gnt}, 2'b10);
    tick();
    tick();
    chk("t2_if_rvalid", if_rvalid, 1);
    chk("t2_if_rdata", if_rdata, ref_mem[11]);
    if_req = 1'b0;
    tick();

    // Test 4: store then load back
    dm_access(1'b1, 10'd7, 32'hDEADBEEF, "t4_store");
    dm_access(1'b0, 10'd7, 32'h0, "t4_load");

    // Test 3: both requesters held continuously; IF must not starve
    if_req = 1'b1; if_addr = 10'd40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd600;
    gap = 0; max_gap = 0; n_if = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      gap++;
      if (if_gnt && dm_gnt) chk("t3_single_gnt", {if_gnt, dm_gnt}, 2'b10);
      if (if_gnt) begin
        if (gap > max_gap) max_gap = gap;
        gap = 0;
        n_if++;
      end
      if (if_rvalid) chk("t3_if_rdata", if_rdata, ref_mem[40]);
      if (dm_rvalid) chk("t3_dm_rdata", dm_rdata, ref_mem[600]);
    end
    chk("t3_max_if_gap_ok", max_gap <= 7, 1);
    chk("t3_if_served", n_if >= 5, 1);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (8) tick();

    // Randomized concurrent traffic: IF reads low half, DM loads/stores high half
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          if_access(10'($urandom_range(0, 511)), "rnd_if");
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          dm_access(1'($urandom_range(0, 1)), 10'($urandom_range(512, 1023)), $urandom, "rnd_dm");
        end
      end
    join
    repeat (4) tick();

    // Test 5: flush during WAIT on the MEM_LAT=3 instance
    if_req_b = 1'b1; if_addr_b = 10'd3;
    tick();
    chk("t5_if_gnt", if_gnt_b, 1);
    chk("t5_mem_addr", mem_addr_b, 3);
    tick();
    if_flush_b = 1'b1; if_addr_b = 10'd9;
    got = 1'b0; gnt2 = 1'b0; early = 0; rd = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if_flush_b = 1'b0;
      if (if_gnt_b) begin
        gnt2 = 1'b1;
        chk("t5_regnt_addr", mem_addr_b, 9);
      end
      if (if_rvalid_b) begin
        if (!gnt2) early++;
        else begin
          got = 1'b1;
          rd  = if_rdata_b;
        end
      end
    end
    if_req_b = 1'b0;
    chk("t5_no_flushed_rvalid", early, 0);
    chk("t5_new_fetch_done", got, 1);
    chk("t5_new_fetch_rdata", rd, ref_mem[9]);
    tick();

    // Test 6: reset in WAIT abandons the access
    if_req_b = 1'b1; if_addr_b = 10'd4;
    tick();
    chk("t6_if_gnt", if_gnt_b, 1);
    tick();
    rst = 1'b1; if_req_b = 1'b0;
    tick();
    chk("t6_rst_ctrl", {if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b, mem_en_b, mem_we_b, stall_if_b, stall_dm_b}, 0);
    chk("t6_rst_rdata", {if_rdata_b, dm_rdata_b}, 0);
    chk("t6_rst_mem_bus", {mem_addr_b, mem_wdata_b}, 0);
`ifdef ARB_PERF_EN
    chk("t6_perf_a", {perf_if_stall, perf_dm_stall}, 0);
    chk("t6_perf_b", {perf_if_stall_b, perf_dm_stall_b}, 0);
    chk("t6_perf_starve", {perf_starve, perf_starve_b}, 0);
`endif
    rst = 1'b0;
    rv = 0;
    repeat (8) begin
      tick();
      if (if_rvalid_b || dm_rvalid_b) rv++;
    end
    chk("t6_no_rvalid_after_rst", rv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
